// File: rtl/mio_arbiter_pkg.sv
// Shared definitions for the MIO bus arbiter: FSM encoding, MIO region codes
// and small helpers used by the arbiter datapath.
package mio_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Top nibble of the byte address selects the MIO region.
    localparam logic [3:0] MIO_RAM     = 4'h0;
    localparam logic [3:0] MIO_CONSOLE = 4'hD;
    localparam logic [3:0] MIO_SEG7    = 4'hE;
    localparam logic [3:0] MIO_GPIO    = 4'hF;

    localparam logic [3:0] BURST_SAT   = 4'hF;

    function automatic logic [3:0] mio_region(input logic [31:0] addr);
        return addr[31:28];
    endfunction

    // Burst counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == BURST_SAT) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mio_arbiter_rr_pick2.sv
// Two-way round-robin selector: with both requesting, the master that was
// not granted last wins; a lone requester always wins.
module rr_pick2
    import mio_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic hit
);

    // Pure combinational pick; last=1 means m1 owned the bus most recently.
    always_comb begin
        hit = req0 | req1;
        win = (req0 && req1) ? ~last : req1;
    end

endmodule

// File: rtl/mio_arbiter.sv
// Arbiter sharing the MIO bus between the CPU (m0) and the auxiliary
// loader/console (m1), with optional locked bursts and a fixed read latency.
module mio_arbiter
    import mio_arbiter_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        mem_w,
    output logic [31:0] addr_bus,
    output logic [31:0] Cpu_data2bus,
    input  logic [31:0] Cpu_data4bus
);

    arb_state_t  state, state_n;
    logic        sel;          // current owner: 0 = m0, 1 = m1
    logic        last_ptr;     // master granted most recently from IDLE
    logic [3:0]  burst_cnt;
    logic [2:0]  wait_cnt;
    logic        we_q;
    logic        start;        // load a new transfer onto the bus
    logic        start_sel;
    logic        capture;      // latch Cpu_data4bus into the owner's rdata
    logic        pick_win;
    logic        pick_hit;
    logic        cur_req;
    logic        cur_lock;

    rr_pick2 u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (last_ptr),
        .win  (pick_win),
        .hit  (pick_hit)
    );

    assign cur_req  = sel ? m1_req  : m0_req;
    assign cur_lock = sel ? m1_lock : m0_lock;

    assign m0_gnt = (state != ST_IDLE) && !sel;
    assign m1_gnt = (state != ST_IDLE) &&  sel;
    assign m0_ack = (state == ST_DONE) && !sel;
    assign m1_ack = (state == ST_DONE) &&  sel;
    // The strobe is gated by rst so a write caught by reset never reaches the decoder.
    assign mem_w  = (state == ST_ACCESS) && we_q && !rst;

    // Next-state decode; requesters are only looked at in IDLE and on DONE exit.
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        start_sel = sel;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_hit) begin
                    state_n   = ST_ACCESS;
                    start     = 1'b1;
                    start_sel = pick_win;
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_n = ST_DONE;
                end else if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 3'(RD_LAT)) begin
                    capture = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                // burst_cnt already counts the transfer just acknowledged.
                if (cur_lock && cur_req && (burst_cnt < 4'(MAX_BURST))) begin
                    state_n = ST_ACCESS;
                    start   = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Control state: FSM, owner, round-robin pointer, burst and wait counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            last_ptr  <= 1'b1;
            burst_cnt <= 4'd0;
            wait_cnt  <= 3'd0;
        end else begin
            state <= state_n;
            if (start) begin
                sel <= start_sel;
            end
            if (start && (state == ST_IDLE)) begin
                last_ptr  <= start_sel;
                burst_cnt <= 4'd0;
            end else if (state_n == ST_DONE) begin
                burst_cnt <= sat_inc4(burst_cnt);
            end
            if (state_n == ST_WAIT) begin
                wait_cnt <= (state == ST_WAIT) ? wait_cnt + 3'd1 : 3'd1;
            end else begin
                wait_cnt <= 3'd0;
            end
        end
    end

    // Bus drive registers and per-master read-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_bus     <= 32'd0;
            Cpu_data2bus <= 32'd0;
            we_q         <= 1'b0;
            m0_rdata     <= 32'd0;
            m1_rdata     <= 32'd0;
        end else begin
            if (start) begin
                addr_bus     <= start_sel ? m1_addr  : m0_addr;
                Cpu_data2bus <= start_sel ? m1_wdata : m0_wdata;
                we_q         <= start_sel ? m1_we    : m0_we;
            end
            if (capture) begin
                if (sel) begin
                    m1_rdata <= Cpu_data4bus;
                end else begin
                    m0_rdata <= Cpu_data4bus;
                end
            end
        end
    end

endmodule

// File: doc/mio_arbiter.md
MIO_ARBITER -- requirements
Module: mio_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: cycles between address issue and valid Cpu_data4bus on reads (range 0-7).
REQ-002 Parameter MAX_BURST, default 4: maximum back-to-back locked transfers before forced re-arbitration (range 1-15).
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 mN_req  in  1  master N (N=0 CPU, N=1 auxiliary loader/console) requests a transfer; held until mN_ack.
REQ-006 mN_we  in  1  1 = write, 0 = read; stable while mN_req high.
REQ-007 mN_lock  in  1  master requests to keep the bus for its next transfer.
REQ-008 mN_addr  in  32  byte address, MIO map (0x0 RAM, 0xD console, 0xE 7-seg, 0xF GPIO/counter).
REQ-009 mN_wdata  in  32  write data.
REQ-010 mN_gnt  out  1  master N currently owns the bus.
REQ-011 mN_ack  out  1  one-cycle pulse: transfer complete, mN_rdata valid.
REQ-012 mN_rdata  out  32  read data, held until next ack to the same master.
REQ-013 mem_w  out  1  bus write strobe to the MIO decoder.
REQ-014 addr_bus  out  32  bus address to the MIO decoder.
REQ-015 Cpu_data2bus  out  32  bus write data.
REQ-016 Cpu_data4bus  in  32  bus read data from the MIO decoder.

Function
REQ-017 FSM states IDLE, ACCESS, WAIT, DONE; exactly one master granted in ACCESS/WAIT/DONE, none in IDLE.
REQ-018 IDLE: if any req, select a master and go to ACCESS next cycle with its gnt registered high.
REQ-019 Selection is round-robin: with both requesting, grant the master not granted last; after reset m0 has priority.
REQ-020 ACCESS (one cycle): drive addr_bus/Cpu_data2bus from granted master; mem_w = mN_we for this cycle only.
REQ-021 Outside ACCESS, mem_w=0; addr_bus/Cpu_data2bus hold their last values.
REQ-022 Write: ACCESS -> DONE; read with RD_LAT=0: capture Cpu_data4bus in ACCESS -> DONE.
REQ-023 Read with RD_LAT>0: ACCESS -> WAIT for RD_LAT cycles, capture Cpu_data4bus on last WAIT cycle -> DONE.
REQ-024 DONE: assert mN_ack for one cycle; rdata updated only on reads.
REQ-025 From DONE: if granted master's lock=1 and burst count < MAX_BURST, keep gnt and return to ACCESS on next cycle where its req=1; else deassert gnt, go IDLE.
REQ-026 Locked master with req=0 in the cycle after DONE releases the bus (to IDLE).
REQ-027 Burst count (4 bits) clears on entry from IDLE, increments each DONE, saturates; reaching MAX_BURST forces release even with lock=1.
REQ-028 Requester inputs are sampled only in IDLE and at DONE exit; changes during a transfer are ignored.
REQ-029 Write-read latency: write ack 2 cycles after grant; read ack 2+RD_LAT cycles after grant.

Reset
REQ-030 On rst: state IDLE, both gnt=0, ack=0, rdata=0, mem_w=0, addr_bus=0, Cpu_data2bus=0, burst count=0, last-grant pointer=m1.
REQ-031 rst mid-transfer aborts it with no ack; a pending write strobe is dropped that cycle.

Structure
REQ-032 Shared package holds FSM state encoding and MIO region codes (4'h0, 4'hD, 4'hE, 4'hF).
REQ-033 One sub-module, rr_pick2: combinational two-way round-robin selector (reqs, last pointer -> winner).

Verification
REQ-034 Single m0 write 0x0000_0010 data 0xA5A5_A5A5 -> mem_w high 1 cycle with that address/data, m0_ack 2 cycles after grant.
REQ-035 m1 read 0xF000_0000, RD_LAT=1, Cpu_data4bus=0x1234_5678 -> m1_ack at grant+3, m1_rdata=0x1234_5678.
REQ-036 m0 and m1 request same cycle from reset, continuously -> grants alternate m0,m1,m0,m1.
REQ-037 m0 lock=1 with 6 queued reads, m1 requesting, MAX_BURST=4 -> 4 m0 acks, then m1 granted.
REQ-038 rst asserted in WAIT -> next cycle all outputs zero, no ack; fresh request completes normally.
